// File: rtl/imem_loader_if.sv
// Purpose : load-request, byte-stream and instruction-memory write signals of imem_loader.
// Latency : n/a (signal bundle only).
// Backpressure: byte stream uses byte_valid/byte_ready; memory writes are fire-and-forget strobes.
// Ports   : master = host side (drives load request and bytes), slave = loader side.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              load_start;
  logic [ADDR_W:0]   word_count;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              cpu_rstn;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output load_start, word_count, byte_valid, byte_data,
    input  byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err
  );

  modport slave (
    input  load_start, word_count, byte_valid, byte_data,
    output byte_ready, im_we, im_addr, im_wdata, cpu_rstn, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Purpose : assembles a little-endian byte stream into 32-bit words and writes them to
//           instruction memory, holding the CPU in reset until the program is loaded.
// Latency : 1 cycle from load_start to COLLECT, then 5 cycles per word minimum (4 bytes + 1 write).
// Backpressure: byte_ready is high only while collecting; byte_valid low stalls without loss.
// Ports   : clk, rstn (async active-low), bus (imem_loader_if.slave: load request, byte stream,
//           memory write port, cpu_rstn and busy/done/err status).
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input logic          clk,
  input logic          rstn,
  imem_loader_if.slave bus
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE   = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t            state;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        byte_cnt;
  logic [31:0]       asm_q;
  logic              byte_ready_q;
  logic              im_we_q;
  logic              cpu_rstn_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;

  // The word being written is the last one when its index equals count-1; count is
  // never zero in WRITE, so the subtraction cannot underflow.
  logic [ADDR_W:0] last_addr;
  logic            last_word;
  assign last_addr = count_q - ONE;
  assign last_word = ({1'b0, addr_q} == last_addr);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= IDLE;
      count_q      <= '0;
      addr_q       <= '0;
      byte_cnt     <= '0;
      asm_q        <= '0;
      byte_ready_q <= 1'b0;
      im_we_q      <= 1'b0;
      cpu_rstn_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.load_start) begin
            if (bus.word_count == '0) begin
              // Skip-load: release the CPU on whatever the memory already holds.
              state      <= DONE;
              done_q     <= 1'b1;
              err_q      <= 1'b0;
              cpu_rstn_q <= 1'b1;
            end else if (bus.word_count > DEPTH) begin
              // Rejected request; done is left alone since no load was accepted.
              state      <= IDLE;
              err_q      <= 1'b1;
              cpu_rstn_q <= 1'b0;
            end else begin
              state        <= COLLECT;
              count_q      <= bus.word_count;
              addr_q       <= '0;
              byte_cnt     <= '0;
              done_q       <= 1'b0;
              err_q        <= 1'b0;
              cpu_rstn_q   <= 1'b0;
              busy_q       <= 1'b1;
              byte_ready_q <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (bus.byte_valid && byte_ready_q) begin
            asm_q[{byte_cnt, 3'b000} +: 8] <= bus.byte_data;
            byte_cnt                       <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state        <= WRITE;
              byte_ready_q <= 1'b0;
              im_we_q      <= 1'b1;
            end
          end
        end

        WRITE: begin
          im_we_q <= 1'b0;
          if (last_word) begin
            state      <= DONE;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            cpu_rstn_q <= 1'b1;
          end else begin
            state        <= COLLECT;
            addr_q       <= addr_q + 1'b1;
            byte_ready_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_q;
  assign bus.im_we      = im_we_q;
  assign bus.im_addr    = addr_q;
  assign bus.im_wdata   = asm_q;
  assign bus.cpu_rstn   = cpu_rstn_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Purpose : directed + randomized bench for imem_loader against a byte-array reference model.
// Latency : checks 1 + 5*n cycles for gap-free n-word loads.
// Backpressure: drives byte_valid with random and directed gaps.
module tb_imem_loader;
  localparam int AW = 8;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(AW)) bus ();
  imem_loader #(.ADDR_W(AW)) dut (.clk(clk), .rstn(rstn), .bus(bus));

  int tests = 0;
  int fails = 0;
  int we_cnt = 0;
  logic [39:0] wr_q[$];
  logic [7:0]  prog[0:1023];

  // Every write strobe seen on the memory port is logged as {addr, data}.
  always @(negedge clk) begin
    if (bus.im_we === 1'b1) begin
      wr_q.push_back({bus.im_addr, bus.im_wdata});
      we_cnt++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word i of the program: bytes 4i..4i+3, least significant byte first.
  function automatic logic [31:0] model_word(input int i);
    logic [31:0] w;
    w = 32'(prog[4*i]) + 32'(prog[4*i+1]) * 32'd256 +
        32'(prog[4*i+2]) * 32'd65536 + 32'(prog[4*i+3]) * 32'd16777216;
    return w;
  endfunction

  task automatic compare_writes(input string tag, input int n);
    check({tag, "_nwr"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check({tag, "_addr"}, 64'(wr_q[i][39:32]), 64'(i));
      check({tag, "_data"}, 64'(wr_q[i][31:0]), 64'(model_word(i)));
    end
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_rdy"},   64'(bus.byte_ready), 64'd0);
    check({tag, "_we"},    64'(bus.im_we), 64'd0);
    check({tag, "_addr"},  64'(bus.im_addr), 64'd0);
    check({tag, "_wdata"}, 64'(bus.im_wdata), 64'd0);
    check({tag, "_busy"},  64'(bus.busy), 64'd0);
    check({tag, "_done"},  64'(bus.done), 64'd0);
    check({tag, "_err"},   64'(bus.err), 64'd0);
    check({tag, "_cpurst"},64'(bus.cpu_rstn), 64'd0);
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) prog[i] = 8'($urandom);
  endtask

  // Issues one load of n words from prog[]; entered and left 1 time unit after a rising edge.
  // cyc counts rising edges from the one sampling load_start up to the one at which done rises.
  task automatic run_load(input int n, input int gap_pct, input int stall_at, input int stall_len,
                          input int restart_at, input int abort_at, output int cyc);
    int   idx;
    int   guard;
    int   stall_left;
    bit   restarted;
    logic v;
    logic rdy;
    wr_q.delete();
    idx = 0; guard = 0; stall_left = stall_len; restarted = 1'b0;
    bus.load_start = 1'b1;
    bus.word_count = 9'(n);
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    cyc = 1;
    check("load_busy", 64'(bus.busy), 64'd1);
    check("load_cpurst", 64'(bus.cpu_rstn), 64'd0);
    while (idx < 4*n && guard < 20000) begin
      if (abort_at >= 0 && idx == abort_at) begin
        bus.byte_valid = 1'b0;
        return;
      end
      v = 1'b1;
      if (stall_at >= 0 && idx == stall_at && stall_left > 0) begin
        v = 1'b0;
        stall_left--;
      end else if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
        v = 1'b0;
      end
      if (!restarted && restart_at >= 0 && idx == restart_at) begin
        bus.load_start = 1'b1;
        bus.word_count = 9'd1;
        restarted = 1'b1;
      end else begin
        bus.load_start = 1'b0;
        bus.word_count = 9'(n);
      end
      bus.byte_valid = v;
      bus.byte_data  = v ? prog[idx] : 8'($urandom);
      rdy = bus.byte_ready;
      @(posedge clk); #1;
      cyc++; guard++;
      if (v && rdy) idx++;
    end
    bus.byte_valid = 1'b0;
    bus.load_start = 1'b0;
    while (bus.done !== 1'b1 && guard < 20000) begin
      @(posedge clk); #1;
      cyc++; guard++;
    end
    if (guard >= 20000) check("load_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int cyc;
    int we_before;
    int n;

    rstn = 1'b0;
    bus.load_start = 1'b0;
    bus.word_count = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    #1;
    check_reset_outs("rst");
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_cpurst", 64'(bus.cpu_rstn), 64'd0);
    check("idle_busy", 64'(bus.busy), 64'd0);
    check("idle_rdy", 64'(bus.byte_ready), 64'd0);

    // Two-word reference program, continuous bytes.
    prog[0] = 8'h13; prog[1] = 8'h05; prog[2] = 8'h00; prog[3] = 8'h00;
    prog[4] = 8'h93; prog[5] = 8'h05; prog[6] = 8'h10; prog[7] = 8'h00;
    run_load(2, 0, -1, 0, -1, -1, cyc);
    check("ref_cycles", 64'(cyc), 64'd11);
    compare_writes("ref", 2);
    if (wr_q.size() == 2) begin
      check("ref_w0", 64'(wr_q[0][31:0]), 64'h0000_0513);
      check("ref_w1", 64'(wr_q[1][31:0]), 64'h0010_0593);
    end
    check("ref_done", 64'(bus.done), 64'd1);
    check("ref_cpurst", 64'(bus.cpu_rstn), 64'd1);
    check("ref_busy", 64'(bus.busy), 64'd0);
    check("ref_rdy", 64'(bus.byte_ready), 64'd0);

    // Same program with a 3-cycle stall after byte 2.
    run_load(2, 0, 2, 3, -1, -1, cyc);
    check("stall_cycles", 64'(cyc), 64'd14);
    compare_writes("stall", 2);
    check("stall_done", 64'(bus.done), 64'd1);

    // Zero-word load: straight to DONE.
    we_before = we_cnt;
    bus.load_start = 1'b1; bus.word_count = 9'd0;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    check("zero_done", 64'(bus.done), 64'd1);
    check("zero_cpurst", 64'(bus.cpu_rstn), 64'd1);
    check("zero_busy", 64'(bus.busy), 64'd0);
    check("zero_we", 64'(we_cnt), 64'(we_before));

    // Oversized request is rejected.
    bus.load_start = 1'b1; bus.word_count = 9'd257;
    @(posedge clk); #1;
    bus.load_start = 1'b0;
    check("big_err", 64'(bus.err), 64'd1);
    check("big_cpurst", 64'(bus.cpu_rstn), 64'd0);
    check("big_busy", 64'(bus.busy), 64'd0);
    repeat (2) @(posedge clk); #1;
    check("big_rdy", 64'(bus.byte_ready), 64'd0);
    check("big_we", 64'(we_cnt), 64'(we_before));

    // Randomized loads with random byte_valid gaps; first one also clears err.
    for (int k = 0; k < 3; k++) begin
      n = $urandom_range(1, 8);
      fill_random(4*n);
      run_load(n, 30, -1, 0, -1, -1, cyc);
      compare_writes("rand", n);
      check("rand_err", 64'(bus.err), 64'd0);
      check("rand_done", 64'(bus.done), 64'd1);
    end

    // load_start re-asserted mid-load is ignored.
    fill_random(16);
    run_load(4, 0, -1, 0, 5, -1, cyc);
    check("restart_cycles", 64'(cyc), 64'd21);
    compare_writes("restart", 4);

    // Reset after two bytes of the second word of a 3-word load.
    fill_random(12);
    run_load(3, 0, -1, 0, -1, 6, cyc);
    #2 rstn = 1'b0;
    #1;
    check_reset_outs("midrst");
    compare_writes("midrst", 1);
    we_before = we_cnt;
    @(posedge clk); #1 rstn = 1'b1;
    repeat (3) @(posedge clk); #1;
    check("midrst_we", 64'(we_cnt), 64'(we_before));
    check("midrst_cpurst", 64'(bus.cpu_rstn), 64'd0);
    fill_random(8);
    run_load(2, 20, -1, 0, -1, -1, cyc);
    compare_writes("after_rst", 2);

    // Full-depth load: last address 255, no wrap.
    fill_random(1024);
    run_load(256, 10, -1, 0, -1, -1, cyc);
    compare_writes("full", 256);
    if (wr_q.size() == 256) check("full_last", 64'(wr_q[255][39:32]), 64'd255);
    check("full_done", 64'(bus.done), 64'd1);
    check("full_cpurst", 64'(bus.cpu_rstn), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, giving the instruction-memory word-address width (depth 2^ADDR_W words).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port load_start  input  1  start-of-load request, sampled each cycle.
REQ-005 SHALL have port word_count  input  ADDR_W+1  number of 32-bit words to load, captured with load_start.
REQ-006 SHALL have port byte_valid  input  1  byte_data holds a program byte.
REQ-007 SHALL have port byte_data  input  8  program byte stream, little-endian within each word.
REQ-008 SHALL have port byte_ready  output  1  loader accepts a byte this cycle.
REQ-009 SHALL have port im_we  output  1  instruction-memory write strobe.
REQ-010 SHALL have port im_addr  output  ADDR_W  instruction-memory word address.
REQ-011 SHALL have port im_wdata  output  32  instruction word to write.
REQ-012 SHALL have port cpu_rstn  output  1  active-low reset to the CPU; low while the program is not loaded.
REQ-013 SHALL have ports busy, done, err  output  1 each  load in progress / load complete / request rejected.

Function
REQ-014 SHALL implement an FSM with states IDLE, COLLECT, WRITE, DONE.
REQ-015 A byte SHALL be accepted only on a rising edge with byte_valid=1 and byte_ready=1.
REQ-016 byte_ready SHALL be 1 only in COLLECT; 0 in IDLE, WRITE, DONE.
REQ-017 In IDLE or DONE, load_start=1 with 0 < word_count <= 2^ADDR_W SHALL capture word_count, clear done/err, drive cpu_rstn=0, zero the address and byte counters, and enter COLLECT next cycle.
REQ-018 In IDLE or DONE, load_start=1 with word_count=0 SHALL enter DONE next cycle with no writes (skip-load; memory keeps prior contents).
REQ-019 In IDLE or DONE, load_start=1 with word_count > 2^ADDR_W SHALL set err=1, enter IDLE, drive cpu_rstn=0, and perform no writes.
REQ-020 load_start SHALL be ignored in COLLECT and WRITE.
REQ-021 The k-th accepted byte of a word (k=0..3) SHALL land in bits [8k+7:8k] of the assembly register.
REQ-022 After the 4th byte is accepted, the FSM SHALL enter WRITE next cycle and assert im_we=1 for exactly one cycle, with im_addr = current word index and im_wdata = the assembled word.
REQ-023 After WRITE, if words written = captured word_count, SHALL enter DONE; otherwise increment im_addr and return to COLLECT.
REQ-024 im_addr SHALL never wrap; the last write address is word_count-1 <= 2^ADDR_W-1.
REQ-025 byte_valid=0 in COLLECT SHALL stall without losing the partial word; minimum cost is 5 cycles per word.
REQ-026 busy SHALL be 1 exactly in COLLECT and WRITE.
REQ-027 In DONE, done=1, cpu_rstn=1, busy=0; done stays set until the next accepted load_start.
REQ-028 im_we SHALL be 0 in every state except WRITE.

Reset
REQ-029 rstn=0 SHALL asynchronously force IDLE, cpu_rstn=0, byte_ready=0, im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0, and clear all counters.
REQ-030 Reset during COLLECT or WRITE SHALL discard the partial word; words already written remain in memory; no further write occurs until a new load_start.
REQ-031 After rstn deasserts, the FSM SHALL remain in IDLE with cpu_rstn=0 until load_start.

Verification
REQ-032 ADDR_W=8, load_start with word_count=2, continuous bytes 13 05 00 00 93 05 10 00 -> writes addr0=0x00000513, addr1=0x00100593; done=1, cpu_rstn=1 eleven cycles after load_start.
REQ-033 Same load with byte_valid dropped for 3 cycles after byte 2 -> identical writes, completion 3 cycles later, no extra im_we.
REQ-034 load_start with word_count=0 -> no im_we, done=1 and cpu_rstn=1 the next cycle.
REQ-035 load_start with word_count=257 (ADDR_W=8) -> err=1, cpu_rstn=0, state IDLE, no im_we.
REQ-036 rstn pulsed low after 2 bytes of word 1 in a 3-word load -> immediately all outputs at reset values, only addr0 written; a new load then starts at addr0.
REQ-037 load_start re-asserted mid-load -> ignored; word_count and address sequence unaffected.
